// File: rtl/sort_arb.sv
`timescale 1ns/1ps
// sort_arb: grants whole packets round-robin from CH_NUM Avalon-ST requesters
// into one shared sort core and tags each forwarded packet with its owner.
// Sorted packets come back from the core and leave on a single source port
// whose channel field is the head of the tag FIFO.
module sort_arb #(
    parameter int  DWIDTH    = 8,
    parameter int  CH_NUM    = 4,
    parameter int  TAG_DEPTH = 4,
    localparam int CH_W      = $clog2(CH_NUM)
) (
    input  logic                     clk_i,
    input  logic                     srst_n_i,
    // requester side
    input  logic [CH_NUM*DWIDTH-1:0] snk_data_i,
    input  logic [CH_NUM-1:0]        snk_startofpacket_i,
    input  logic [CH_NUM-1:0]        snk_endofpacket_i,
    input  logic [CH_NUM-1:0]        snk_valid_i,
    output logic [CH_NUM-1:0]        snk_ready_o,
    // stream into the sort core
    output logic [DWIDTH-1:0]        core_data_o,
    output logic                     core_startofpacket_o,
    output logic                     core_endofpacket_o,
    output logic                     core_valid_o,
    input  logic                     core_ready_i,
    // stream out of the sort core
    input  logic [DWIDTH-1:0]        core_data_i,
    input  logic                     core_startofpacket_i,
    input  logic                     core_endofpacket_i,
    input  logic                     core_valid_i,
    output logic                     core_ready_o,
    // sorted, tagged output
    output logic [DWIDTH-1:0]        src_data_o,
    output logic                     src_startofpacket_o,
    output logic                     src_endofpacket_o,
    output logic                     src_valid_o,
    output logic [CH_W-1:0]          src_channel_o,
    input  logic                     src_ready_i,
    output logic                     drop_o
);

    localparam int PTR_W = (TAG_DEPTH > 1) ? $clog2(TAG_DEPTH) : 1;
    localparam int CNT_W = $clog2(TAG_DEPTH) + 1;
    localparam logic [CH_W-1:0]  LAST_CH  = CH_W'(CH_NUM - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(TAG_DEPTH);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_PASS = 1'b1
    } state_t;

    // First requester at or above ptr, wrapping past the last channel.
    function automatic logic [CH_W-1:0] rr_pick(input logic [CH_NUM-1:0] req,
                                                 input logic [CH_W-1:0]   ptr);
        logic [CH_W-1:0] pick;
        logic            found;
        int              idx;
        pick  = ptr;
        found = 1'b0;
        for (int i = 0; i < CH_NUM; i++) begin
            idx = (int'(ptr) + i) % CH_NUM;
            if (!found && req[idx]) begin
                pick  = CH_W'(idx);
                found = 1'b1;
            end else begin
                found = found;
            end
        end
        return pick;
    endfunction

    // Tag FIFO pointer increment that also works for non-power-of-2 depths.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(TAG_DEPTH - 1)) ? {PTR_W{1'b0}} : p + 1'b1;
    endfunction

    state_t            state_r, state_nxt_s;
    logic [CH_W-1:0]   gnt_r, gnt_nxt_s;
    logic [CH_W-1:0]   rr_ptr_r, rr_ptr_nxt_s;
    logic [CH_NUM-1:0] req_s, orphan_s;
    logic [DWIDTH-1:0] ch_data_s [CH_NUM];

    logic [CH_W-1:0]   tag_mem_r [TAG_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_r, rd_ptr_r;
    logic [CNT_W-1:0]  cnt_r;
    logic              full_s, empty_s, push_s, pop_s;

    logic [CH_NUM-1:0] snk_ready_s;
    logic              drop_s;
    logic [DWIDTH-1:0] core_data_s;
    logic              core_sop_s, core_eop_s, core_valid_s;
    logic              src_valid_s, core_ready_s;
    logic [CH_W-1:0]   chan_s;

    assign req_s    = snk_valid_i & snk_startofpacket_i;
    assign orphan_s = snk_valid_i & ~snk_startofpacket_i;
    assign full_s   = (cnt_r == FULL_CNT);
    assign empty_s  = (cnt_r == {CNT_W{1'b0}});

    // Split the flat requester data bus into per-channel words.
    always_comb begin
        for (int k = 0; k < CH_NUM; k++) begin
            ch_data_s[k] = snk_data_i[k*DWIDTH +: DWIDTH];
        end
    end

    // Arbitration FSM: next state, grant, forward mux and sink readies.
    always_comb begin
        state_nxt_s  = state_r;
        gnt_nxt_s    = gnt_r;
        rr_ptr_nxt_s = rr_ptr_r;
        push_s       = 1'b0;
        snk_ready_s  = {CH_NUM{1'b0}};
        drop_s       = 1'b0;
        core_data_s  = {DWIDTH{1'b0}};
        core_sop_s   = 1'b0;
        core_eop_s   = 1'b0;
        core_valid_s = 1'b0;
        if (!srst_n_i) begin
            state_nxt_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    // orphans are accepted and thrown away; requesters wait
                    snk_ready_s = orphan_s;
                    drop_s      = |orphan_s;
                    if ((|req_s) && !full_s) begin
                        gnt_nxt_s   = rr_pick(req_s, rr_ptr_r);
                        state_nxt_s = ST_PASS;
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end
                ST_PASS: begin
                    core_data_s         = ch_data_s[gnt_r];
                    core_sop_s          = snk_startofpacket_i[gnt_r];
                    core_eop_s          = snk_endofpacket_i[gnt_r];
                    core_valid_s        = snk_valid_i[gnt_r];
                    snk_ready_s[gnt_r]  = core_ready_i;
                    if (core_valid_s && core_ready_i && core_eop_s) begin
                        push_s       = 1'b1;
                        rr_ptr_nxt_s = (gnt_r == LAST_CH) ? {CH_W{1'b0}} : gnt_r + 1'b1;
                        state_nxt_s  = ST_IDLE;
                    end else begin
                        state_nxt_s = ST_PASS;
                    end
                end
                default: begin
                    state_nxt_s = ST_IDLE;
                end
            endcase
        end
    end

    // Return path: output is held back until an owner tag is available.
    always_comb begin
        src_valid_s  = 1'b0;
        core_ready_s = 1'b0;
        pop_s        = 1'b0;
        chan_s       = {CH_W{1'b0}};
        if (srst_n_i && !empty_s) begin
            src_valid_s  = core_valid_i;
            core_ready_s = src_ready_i;
            chan_s       = tag_mem_r[rd_ptr_r];
            pop_s        = core_valid_i && src_ready_i && core_endofpacket_i;
        end else begin
            pop_s = 1'b0;
        end
    end

    // FSM state, current grant and round-robin pointer.
    always_ff @(posedge clk_i) begin
        if (!srst_n_i) begin
            state_r  <= ST_IDLE;
            gnt_r    <= {CH_W{1'b0}};
            rr_ptr_r <= {CH_W{1'b0}};
        end else begin
            state_r  <= state_nxt_s;
            gnt_r    <= gnt_nxt_s;
            rr_ptr_r <= rr_ptr_nxt_s;
        end
    end

    // Tag FIFO: push on forwarded eop, pop on returned eop, both may coincide.
    always_ff @(posedge clk_i) begin
        if (!srst_n_i) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            cnt_r    <= {CNT_W{1'b0}};
            for (int i = 0; i < TAG_DEPTH; i++) begin
                tag_mem_r[i] <= {CH_W{1'b0}};
            end
        end else begin
            if (push_s) begin
                tag_mem_r[wr_ptr_r] <= gnt_r;
                wr_ptr_r            <= ptr_inc(wr_ptr_r);
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_r <= ptr_inc(rd_ptr_r);
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
            case ({push_s, pop_s})
                2'b10:   cnt_r <= cnt_r + 1'b1;
                2'b01:   cnt_r <= cnt_r - 1'b1;
                default: cnt_r <= cnt_r;
            endcase
        end
    end

    assign snk_ready_o          = snk_ready_s;
    assign drop_o               = drop_s;
    assign core_data_o          = core_data_s;
    assign core_startofpacket_o = core_sop_s;
    assign core_endofpacket_o   = core_eop_s;
    assign core_valid_o         = core_valid_s;
    assign core_ready_o         = core_ready_s;
    assign src_data_o           = core_data_i;
    assign src_startofpacket_o  = core_startofpacket_i;
    assign src_endofpacket_o    = core_endofpacket_i;
    assign src_valid_o          = src_valid_s;
    assign src_channel_o        = chan_s;

endmodule

// File: tb/tb_sort_arb.sv
`timescale 1ns/1ps
// tb_sort_arb: directed packets into sort_arb with a behavioural sort core.
// Expected core-side and output-side words are queued when stimulus is
// issued; a negedge monitor pops and compares on every transfer.
module tb_sort_arb;

    typedef logic [7:0] bq_t [$];
    typedef struct packed {
        logic [7:0] d;
        logic       sop;
        logic       eop;
        logic [1:0] ch;
    } word_t;

    logic        clk;
    logic        srst_n;
    logic [31:0] snk_data;
    logic [3:0]  snk_sop, snk_eop, snk_valid, snk_ready_o;
    logic [7:0]  core_data_o, core_data_i, src_data_o;
    logic        core_sop_o, core_eop_o, core_valid_o, core_ready_i;
    logic        core_sop_i, core_eop_i, core_valid_i, core_ready_o;
    logic        src_sop_o, src_eop_o, src_valid_o, src_ready_i, drop_o;
    logic [1:0]  src_channel_o;

    logic [7:0]  ch_data [4];
    logic        ch_sop [4], ch_eop [4], ch_valid [4], ch_busy [4];

    word_t exp_core_q[$], exp_out_q[$], model_out_q[$];
    logic [7:0] cap_q[$];
    int    sop_cyc_q[$];
    bq_t   pk [4];
    bq_t   sr [4];
    int    n_cmp = 0, n_err = 0, cyc = 0;

    sort_arb #(.DWIDTH(8), .CH_NUM(4), .TAG_DEPTH(4)) dut (
        .clk_i(clk), .srst_n_i(srst_n),
        .snk_data_i(snk_data), .snk_startofpacket_i(snk_sop),
        .snk_endofpacket_i(snk_eop), .snk_valid_i(snk_valid), .snk_ready_o(snk_ready_o),
        .core_data_o(core_data_o), .core_startofpacket_o(core_sop_o),
        .core_endofpacket_o(core_eop_o), .core_valid_o(core_valid_o), .core_ready_i(core_ready_i),
        .core_data_i(core_data_i), .core_startofpacket_i(core_sop_i),
        .core_endofpacket_i(core_eop_i), .core_valid_i(core_valid_i), .core_ready_o(core_ready_o),
        .src_data_o(src_data_o), .src_startofpacket_o(src_sop_o),
        .src_endofpacket_o(src_eop_o), .src_valid_o(src_valid_o),
        .src_channel_o(src_channel_o), .src_ready_i(src_ready_i), .drop_o(drop_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // cycle counter used for inter-packet spacing
    always @(posedge clk) cyc <= cyc + 1;

    // pack per-channel driver variables onto the flat sink buses
    always_comb begin
        for (int k = 0; k < 4; k++) begin
            snk_data[k*8 +: 8] = ch_data[k];
            snk_sop[k]         = ch_sop[k];
            snk_eop[k]         = ch_eop[k];
            snk_valid[k]       = ch_valid[k];
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // queue what the core must receive and, optionally, what must come out
    task automatic push_pkt(input int ch, input bq_t in_w, input bq_t srt, input bit with_out);
        word_t w;
        for (int i = 0; i < in_w.size(); i++) begin
            w.d = in_w[i]; w.sop = (i == 0); w.eop = (i == in_w.size() - 1); w.ch = 2'(ch);
            exp_core_q.push_back(w);
        end
        if (with_out) begin
            for (int i = 0; i < srt.size(); i++) begin
                w.d = srt[i]; w.sop = (i == 0); w.eop = (i == srt.size() - 1); w.ch = 2'(ch);
                exp_out_q.push_back(w);
            end
        end
    endtask

    // drive one packet on a channel, one word per handshake
    task automatic send_pkt(input int ch, input bq_t w);
        logic hs;
        int   t;
        ch_busy[ch] = 1'b1;
        for (int i = 0; i < w.size(); i++) begin
            ch_data[ch]  = w[i];
            ch_sop[ch]   = (i == 0);
            ch_eop[ch]   = (i == w.size() - 1);
            ch_valid[ch] = 1'b1;
            hs = 1'b0;
            t  = 0;
            while (!hs && t < 500) begin
                @(negedge clk);
                hs = snk_ready_o[ch];
                @(posedge clk);
                #1;
                t++;
            end
            if (!hs) begin
                check("drv_timeout", 32'(hs), 32'd1);
                break;
            end
        end
        ch_valid[ch] = 1'b0;
        ch_sop[ch]   = 1'b0;
        ch_eop[ch]   = 1'b0;
        ch_busy[ch]  = 1'b0;
    endtask

    // wait (bounded) until drivers are idle and expected queues drained
    task automatic wait_for(input int budget, input string name, input bit need_out);
        bit done;
        int t;
        t = 0;
        done = 1'b0;
        while (!done && t < budget) begin
            done = !(ch_busy[0] | ch_busy[1] | ch_busy[2] | ch_busy[3]) &&
                   (exp_core_q.size() == 0) && (!need_out || exp_out_q.size() == 0);
            if (!done) tick();
            t++;
        end
        check(name, 32'(done), 32'd1);
    endtask

    // behavioural sort core: buffers a packet, then replays it ascending
    initial begin
        logic hs, in_rst;
        logic [7:0] tmp;
        word_t w;
        core_data_i = 8'h00; core_sop_i = 1'b0; core_eop_i = 1'b0; core_valid_i = 1'b0;
        forever begin
            @(negedge clk);
            hs     = core_valid_i && core_ready_o;
            in_rst = !srst_n;
            if (!in_rst && core_valid_o && core_ready_i) begin
                if (core_sop_o) cap_q.delete();
                cap_q.push_back(core_data_o);
                if (core_eop_o) begin
                    for (int i = 1; i < cap_q.size(); i++) begin
                        for (int j = i; j > 0; j--) begin
                            if (cap_q[j-1] > cap_q[j]) begin
                                tmp = cap_q[j]; cap_q[j] = cap_q[j-1]; cap_q[j-1] = tmp;
                            end
                        end
                    end
                    for (int i = 0; i < cap_q.size(); i++) begin
                        w.d = cap_q[i]; w.sop = (i == 0); w.eop = (i == cap_q.size() - 1);
                        w.ch = 2'd0;
                        model_out_q.push_back(w);
                    end
                    cap_q.delete();
                end
            end
            @(posedge clk);
            #1;
            if (in_rst) begin
                cap_q.delete();
                model_out_q.delete();
            end else if (hs) begin
                void'(model_out_q.pop_front());
            end
            if (model_out_q.size() > 0) begin
                core_data_i = model_out_q[0].d; core_sop_i = model_out_q[0].sop;
                core_eop_i = model_out_q[0].eop; core_valid_i = 1'b1;
            end else begin
                core_valid_i = 1'b0; core_sop_i = 1'b0; core_eop_i = 1'b0;
            end
        end
    end

    // scoreboard monitor: compare every core-side and output-side transfer
    always @(negedge clk) begin : mon
        word_t e;
        if (core_valid_o && core_ready_i) begin
            if (exp_core_q.size() == 0) begin
                n_cmp++; n_err++;
                $display("FAIL core_unexpected: got word %0h expected none", core_data_o);
            end else begin
                e = exp_core_q.pop_front();
                check("core_data", 32'(core_data_o), 32'(e.d));
                check("core_sop", 32'(core_sop_o), 32'(e.sop));
                check("core_eop", 32'(core_eop_o), 32'(e.eop));
                if (core_sop_o) sop_cyc_q.push_back(cyc);
            end
        end
        if (src_valid_o && src_ready_i) begin
            if (exp_out_q.size() == 0) begin
                n_cmp++; n_err++;
                $display("FAIL src_unexpected: got word %0h expected none", src_data_o);
            end else begin
                e = exp_out_q.pop_front();
                check("src_data", 32'(src_data_o), 32'(e.d));
                check("src_sop", 32'(src_sop_o), 32'(e.sop));
                check("src_eop", 32'(src_eop_o), 32'(e.eop));
                check("src_channel", 32'(src_channel_o), 32'(e.ch));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int viol;
        for (int k = 0; k < 4; k++) begin
            ch_data[k] = 8'h00; ch_sop[k] = 1'b0; ch_eop[k] = 1'b0;
            ch_valid[k] = 1'b0; ch_busy[k] = 1'b0;
        end
        srst_n = 1'b0; core_ready_i = 1'b1; src_ready_i = 1'b1;
        repeat (3) tick();
        srst_n = 1'b1;
        @(negedge clk);
        check("rst_snk_ready", 32'(snk_ready_o), 32'd0);
        check("rst_core_valid", 32'(core_valid_o), 32'd0);
        check("rst_src_valid", 32'(src_valid_o), 32'd0);
        check("rst_core_ready", 32'(core_ready_o), 32'd0);
        check("rst_drop", 32'(drop_o), 32'd0);
        check("rst_channel", 32'(src_channel_o), 32'd0);
        tick();

        // channels 0,1,3 request together with rr_ptr=0
        pk[0] = {8'h30, 8'h10, 8'h20}; sr[0] = {8'h10, 8'h20, 8'h30};
        pk[1] = {8'h02, 8'h01};        sr[1] = {8'h01, 8'h02};
        pk[3] = {8'hFF, 8'h00, 8'h80}; sr[3] = {8'h00, 8'h80, 8'hFF};
        push_pkt(0, pk[0], sr[0], 1'b1);
        push_pkt(1, pk[1], sr[1], 1'b1);
        push_pkt(3, pk[3], sr[3], 1'b1);
        sop_cyc_q.delete();
        fork
            send_pkt(0, pk[0]);
            send_pkt(1, pk[1]);
            send_pkt(3, pk[3]);
        join_none
        wait_for(400, "rr3_drain", 1'b1);
        check("rr3_nsop", 32'(sop_cyc_q.size()), 32'd3);
        if (sop_cyc_q.size() == 3) begin
            check("gap_0_to_1", 32'(sop_cyc_q[1] - sop_cyc_q[0]), 32'd4);
            check("gap_1_to_3", 32'(sop_cyc_q[2] - sop_cyc_q[1]), 32'd3);
        end

        // channel 2 alone, 10-word packet
        pk[2] = {8'h3C, 8'hA1, 8'h07, 8'hF0, 8'h55, 8'h12, 8'h9E, 8'h07, 8'hC3, 8'h40};
        sr[2] = {8'h07, 8'h07, 8'h12, 8'h3C, 8'h40, 8'h55, 8'h9E, 8'hA1, 8'hC3, 8'hF0};
        push_pkt(2, pk[2], sr[2], 1'b1);
        fork send_pkt(2, pk[2]); join_none
        wait_for(400, "ch2_drain", 1'b1);

        // channel 1 single-word packet 0x5A: one bubble, then forwarded
        pk[1] = {8'h5A}; sr[1] = {8'h5A};
        push_pkt(1, pk[1], sr[1], 1'b1);
        ch_data[1] = 8'h5A; ch_sop[1] = 1'b1; ch_eop[1] = 1'b1; ch_valid[1] = 1'b1;
        @(negedge clk);
        check("bubble_core_valid", 32'(core_valid_o), 32'd0);
        check("bubble_snk_ready", 32'(snk_ready_o), 32'd0);
        tick();
        @(negedge clk);
        check("single_core_valid", 32'(core_valid_o), 32'd1);
        check("single_snk_ready", 32'(snk_ready_o), 32'b0010);
        tick();
        ch_valid[1] = 1'b0; ch_sop[1] = 1'b0; ch_eop[1] = 1'b0;
        wait_for(400, "single_drain", 1'b1);

        // rr_ptr now 2: channels 0 and 2 together -> 2 first, then 0
        pk[2] = {8'h05, 8'h04}; sr[2] = {8'h04, 8'h05};
        pk[0] = {8'h09};        sr[0] = {8'h09};
        push_pkt(2, pk[2], sr[2], 1'b1);
        push_pkt(0, pk[0], sr[0], 1'b1);
        fork
            send_pkt(0, pk[0]);
            send_pkt(2, pk[2]);
        join_none
        wait_for(400, "rr2_drain", 1'b1);

        // orphans on channels 0 and 2 in IDLE
        ch_data[0] = 8'hEE; ch_valid[0] = 1'b1;
        ch_data[2] = 8'hDD; ch_valid[2] = 1'b1;
        @(negedge clk);
        check("orphan_ready", 32'(snk_ready_o), 32'b0101);
        check("orphan_drop", 32'(drop_o), 32'd1);
        check("orphan_core_valid", 32'(core_valid_o), 32'd0);
        tick();
        ch_valid[0] = 1'b0; ch_valid[2] = 1'b0;
        @(negedge clk);
        check("orphan_drop_end", 32'(drop_o), 32'd0);
        tick();

        // tag FIFO full: rr_ptr=1 so order 1,2,3,0, then a 5th packet waits
        src_ready_i = 1'b0;
        pk[1] = {8'h44, 8'h33};        sr[1] = {8'h33, 8'h44};
        pk[2] = {8'h06, 8'h60, 8'h03}; sr[2] = {8'h03, 8'h06, 8'h60};
        pk[3] = {8'h81};               sr[3] = {8'h81};
        pk[0] = {8'hB0, 8'hA0};        sr[0] = {8'hA0, 8'hB0};
        push_pkt(1, pk[1], sr[1], 1'b1);
        push_pkt(2, pk[2], sr[2], 1'b1);
        push_pkt(3, pk[3], sr[3], 1'b1);
        push_pkt(0, pk[0], sr[0], 1'b1);
        fork
            send_pkt(0, pk[0]);
            send_pkt(1, pk[1]);
            send_pkt(2, pk[2]);
            send_pkt(3, pk[3]);
        join_none
        wait_for(400, "full_fill", 1'b0);
        pk[1] = {8'h7F, 8'h00, 8'h7E}; sr[1] = {8'h00, 8'h7E, 8'h7F};
        push_pkt(1, pk[1], sr[1], 1'b1);
        fork send_pkt(1, pk[1]); join_none
        viol = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (core_valid_o || snk_ready_o[1]) viol++;
            tick();
        end
        check("full_no_grant", 32'(viol), 32'd0);
        @(negedge clk);
        check("full_src_valid", 32'(src_valid_o), 32'd1);
        check("full_head_tag", 32'(src_channel_o), 32'd1);
        tick();
        src_ready_i = 1'b1;
        wait_for(600, "full_drain", 1'b1);

        // reset mid-packet with one tag still queued
        src_ready_i = 1'b0;
        pk[0] = {8'h34, 8'h12}; sr[0] = {8'h12, 8'h34};
        push_pkt(0, pk[0], sr[0], 1'b0);
        fork send_pkt(0, pk[0]); join_none
        wait_for(400, "rst_pre_pkt", 1'b0);
        @(negedge clk);
        check("rst_pre_src_valid", 32'(src_valid_o), 32'd1);
        check("rst_pre_tag", 32'(src_channel_o), 32'd0);
        tick();
        exp_core_q.push_back('{d: 8'h11, sop: 1'b1, eop: 1'b0, ch: 2'd1});
        exp_core_q.push_back('{d: 8'h22, sop: 1'b0, eop: 1'b0, ch: 2'd1});
        ch_data[1] = 8'h11; ch_sop[1] = 1'b1; ch_eop[1] = 1'b0; ch_valid[1] = 1'b1;
        tick();
        tick();
        ch_data[1] = 8'h22; ch_sop[1] = 1'b0;
        tick();
        ch_data[1] = 8'h33;
        srst_n = 1'b0;
        @(negedge clk);
        check("inrst_snk_ready", 32'(snk_ready_o), 32'd0);
        check("inrst_core_valid", 32'(core_valid_o), 32'd0);
        tick();
        srst_n = 1'b1; ch_valid[1] = 1'b0; src_ready_i = 1'b1;
        @(negedge clk);
        check("postrst_snk_ready", 32'(snk_ready_o), 32'd0);
        check("postrst_core_valid", 32'(core_valid_o), 32'd0);
        check("postrst_src_valid", 32'(src_valid_o), 32'd0);
        check("postrst_fifo_empty", 32'(core_ready_o), 32'd0);
        check("postrst_channel", 32'(src_channel_o), 32'd0);
        check("postrst_drop", 32'(drop_o), 32'd0);
        check("postrst_core_q", 32'(exp_core_q.size()), 32'd0);
        tick();

        // fresh packet from channel 3 after reset
        pk[3] = {8'hC0, 8'h0C}; sr[3] = {8'h0C, 8'hC0};
        push_pkt(3, pk[3], sr[3], 1'b1);
        fork send_pkt(3, pk[3]); join_none
        wait_for(400, "post_rst_drain", 1'b1);

        repeat (4) tick();
        check("end_queues_empty", 32'(exp_core_q.size() + exp_out_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/sort_arb.md
# sort_arb

Packet-level arbiter and return-path tagger that shares one `sort` engine between `CH_NUM` Avalon-ST requesters. It grants whole packets round-robin, forwards the granted stream into the sort core, and records the owner of each forwarded packet in a tag FIFO. Sorted packets from the core are presented on a single source port with `src_channel_o` naming the owner. It sits between the per-channel producers and the `sort` instance.

## Interface
- `DWIDTH`, 8, data word width; matches the sort core.
- `CH_NUM`, 4, number of requesters; must be at least 2. `CH_W = $clog2(CH_NUM)` is derived and is not overridable.
- `TAG_DEPTH`, 4, maximum number of packets that may be granted but not yet returned; must be a power of 2.
- `clk_i`  in  1  single clock.
- `srst_n_i`  in  1  reset; synchronous, active-low.
- `snk_data_i`  in  CH_NUM*DWIDTH  requester data; channel k occupies bits [k*DWIDTH +: DWIDTH].
- `snk_startofpacket_i`, `snk_endofpacket_i`, `snk_valid_i`  in  CH_NUM each  per-channel framing and valid.
- `snk_ready_o`  out  CH_NUM  per-channel ready.
- `core_data_o`, `core_startofpacket_o`, `core_endofpacket_o`, `core_valid_o`  out  DWIDTH/1/1/1  stream into the sort core sink.
- `core_ready_i`  in  1  sort core `snk_ready`.
- `core_data_i`, `core_startofpacket_i`, `core_endofpacket_i`, `core_valid_i`  in  DWIDTH/1/1/1  sort core source.
- `core_ready_o`  out  1  drives sort core `src_ready`.
- `src_data_o`, `src_startofpacket_o`, `src_endofpacket_o`, `src_valid_o`  out  DWIDTH/1/1/1  sorted output.
- `src_channel_o`  out  CH_W  owner of the current output packet.
- `src_ready_i`  in  1  downstream ready.
- `drop_o`  out  1  one-cycle pulse for each discarded orphan word.

## Operation
- A transfer occurs on any port when valid and ready are both high on a rising edge.
- FSM states: IDLE and PASS. Registers: `gnt` (CH_W), `rr_ptr` (CH_W), tag FIFO (TAG_DEPTH x CH_W) with a count of width `$clog2(TAG_DEPTH)+1`.
- IDLE:
  - Requesters are channels with `snk_valid_i[k] && snk_startofpacket_i[k]`.
  - If any requester exists and the FIFO is not full, `gnt` is set to the first requester searching from `rr_ptr` upward with wrap. The state moves to PASS.
  - All `snk_ready_o` are 0 for requesters in IDLE.
  - A channel with valid high and sop low in IDLE is an orphan. It gets `snk_ready_o[k]=1`, the word is discarded, and `drop_o` pulses. Several orphans on the same cycle produce a single pulse.
- PASS:
  - `core_*_o` is a combinational mux of channel `gnt`. `core_valid_o = snk_valid_i[gnt]`.
  - `snk_ready_o[gnt] = core_ready_i`. All other readies are 0.
  - On the eop transfer: push `gnt` into the FIFO, set `rr_ptr = gnt+1` (wrapping CH_NUM-1 to 0), and return to IDLE.
  - A sop inside a packet is forwarded unchanged.
- Return path:
  - `src_data/sop/eop_o` follow `core_*_i` combinationally.
  - `src_valid_o = core_valid_i && !empty`.
  - `core_ready_o = src_ready_i && !empty`.
  - `src_channel_o` is the FIFO head.
  - The FIFO pops on a src transfer with eop.
- Simultaneous FIFO push and pop: the count is unchanged and both operations take effect.
- FIFO full: no new grant is issued. A packet already in PASS completes, because its push happens only on eop and the FIFO was not full at grant.
- FIFO empty: the output is stalled. Core words are held, not dropped.

## Timing
- Reset values:
  - state=IDLE, rr_ptr=0, gnt=0, FIFO empty.
  - All valid, sop, eop, ready and `drop_o` outputs are 0, since no channel is valid-qualified while in reset.
  - `src_channel_o=0`.
- Reset mid-packet abandons the grant and flushes tags. The sort core is reset on the same cycle by the system.
- Arbitration costs 1 bubble cycle: sop valid at cycle t gives the first forwarded transfer at t+1 at the earliest. A single-word packet (sop and eop together) therefore occupies 2 cycles.
- Data paths have 0-cycle latency with no registers in the data path. Back-to-back packets from different channels are separated by exactly 1 idle cycle when `core_ready_i` is held high.

## Test plan
- Channel 2 alone sends a 10-word random packet -> the core receives it unchanged. After sorting, `src_channel_o=2` for all 10 output words and the output is sorted ascending.
- Channels 0, 1 and 3 raise sop in the same cycle with `rr_ptr=0` -> grants go in the order 0, 1, 3. Returned packets carry tags 0, 1, 3 in that order.
- Channel 1 sends sop and eop on the same word with value 0x5A -> a 1-word output of 0x5A with tag 1. `rr_ptr` becomes 2.
- Channel 0 sends a word with valid=1, sop=0 in IDLE -> `snk_ready_o[0]=1` and `drop_o` pulses once. Nothing reaches the core.
- `src_ready_i=0` while 4 packets are granted -> the FIFO is full and a 5th sop is not granted. Raising `src_ready_i` returns all 4 packets with correct tags, then the 5th packet is granted.
- `srst_n_i` is pulled low for 1 cycle mid-packet -> the next cycle shows all outputs at their reset values and an empty FIFO. A fresh packet from channel 3 is then granted normally.
